// File: rtl/apb_master_bridge_if.sv
// Command/response port and APB requester bus for apb_master_bridge.
// The master modport is the bridge's view. The slave modport is the view of the command source and the completer.
interface apb_master_bridge_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              pen;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, pen, paddr, pwrite, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, pen, paddr, pwrite, pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into IDLE->SETUP->ACCESS transfers,
// with a bounded ACCESS wait (timeout abort) and optional back-to-back issue.
module apb_master_bridge #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned BACK2BACK = 1
) (
   input logic                 pclk,
   input logic                 prst,
   apb_master_bridge_if.master bus
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             b2b_en_c;
   logic             timeout_hit_c;
   logic             cmd_ready_c;

   // Ready is combinational from state. The completing ACCESS cycle opens it only in back-to-back mode.
   always_comb begin
      b2b_en_c      = (BACK2BACK != 0);
      timeout_hit_c = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);
      cmd_ready_c   = 1'b0;
      if (!prst) begin
         case (state)
            ST_IDLE:   cmd_ready_c = 1'b1;
            ST_ACCESS: cmd_ready_c = b2b_en_c && bus.pready;
            default:   cmd_ready_c = 1'b0;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_c;

   // Sequencer: state, APB drive and response pulse, all registered.
   always_ff @(posedge pclk) begin
      if (prst) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         bus.psel      <= 1'b0;
         bus.pen       <= 1'b0;
         bus.paddr     <= '0;
         bus.pwrite    <= 1'b0;
         bus.pwdata    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  bus.paddr  <= bus.cmd_addr;
                  bus.pwrite <= bus.cmd_write;
                  bus.pwdata <= bus.cmd_wdata;
                  bus.psel   <= 1'b1;
                  bus.pen    <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               bus.pen <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.pready) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                  if (b2b_en_c && bus.cmd_valid) begin
                     // Chain straight into SETUP. psel stays high.
                     bus.paddr  <= bus.cmd_addr;
                     bus.pwrite <= bus.cmd_write;
                     bus.pwdata <= bus.cmd_wdata;
                     bus.pen    <= 1'b0;
                     wait_cnt   <= '0;
                     state      <= ST_SETUP;
                  end else begin
                     bus.psel <= 1'b0;
                     bus.pen  <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end else if (timeout_hit_c) begin
                  bus.psel      <= 1'b0;
                  bus.pen       <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  state         <= ST_IDLE;
               end else if (wait_cnt != CNT_SAT) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               bus.psel <= 1'b0;
               bus.pen  <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: per-cycle vector table plus timeout and reset sequences.
module tb_apb_master_bridge;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   logic pclk = 1'b0;
   logic prst;

   always #5 pclk = ~pclk;

   apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16), .BACK2BACK(1)
   ) dut (
      .pclk(pclk),
      .prst(prst),
      .bus (bus)
   );

   typedef struct {
      logic       cv, cw;
      logic [7:0] ca, cwd;
      logic       pr;
      logic [7:0] prd;
      logic       e_rdy;
      logic       e_psel, e_pen;
      logic [7:0] e_paddr;
      logic       e_pwrite;
      logic [7:0] e_pwdata;
      logic       e_rv;
      logic [7:0] e_rd;
      logic       e_err;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic cv, input logic cw, input logic [7:0] ca,
                        input logic [7:0] cwd, input logic pr, input logic [7:0] prd);
      bus.cmd_valid = cv;
      bus.cmd_write = cw;
      bus.cmd_addr  = ca;
      bus.cmd_wdata = cwd;
      bus.pready    = pr;
      bus.prdata    = prd;
   endtask

   function automatic vec_t mkv(
      input logic cv, input logic cw, input logic [7:0] ca, input logic [7:0] cwd,
      input logic pr, input logic [7:0] prd, input logic rdy,
      input logic psel, input logic pen, input logic [7:0] paddr, input logic pwrite,
      input logic [7:0] pwdata, input logic rv, input logic [7:0] rd, input logic err);
      vec_t v;
      v.cv = cv; v.cw = cw; v.ca = ca; v.cwd = cwd; v.pr = pr; v.prd = prd;
      v.e_rdy = rdy; v.e_psel = psel; v.e_pen = pen; v.e_paddr = paddr;
      v.e_pwrite = pwrite; v.e_pwdata = pwdata; v.e_rv = rv; v.e_rd = rd; v.e_err = err;
      return v;
   endfunction

   vec_t vt[18];

   initial begin
      int  acc;
      bit  got;

      // Columns: cv cw addr wdata pready prdata | rdy(during) psel pen paddr pwrite pwdata rv rdata err (after edge)
      // Single write 0x10 <- 0xA5
      vt[0]  = mkv(1, 1, 8'h10, 8'hA5, 0, 8'h00, 1, 1, 0, 8'h10, 1, 8'hA5, 0, 8'h00, 0);
      vt[1]  = mkv(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 8'h10, 1, 8'hA5, 0, 8'h00, 0);
      vt[2]  = mkv(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 8'h10, 1, 8'hA5, 1, 8'h00, 0);
      // Read 0x10, completer returns 0xA5
      vt[3]  = mkv(1, 0, 8'h10, 8'h00, 0, 8'h00, 1, 1, 0, 8'h10, 0, 8'h00, 0, 8'h00, 0);
      vt[4]  = mkv(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 8'h10, 0, 8'h00, 0, 8'h00, 0);
      vt[5]  = mkv(0, 0, 8'h00, 8'h00, 1, 8'hA5, 1, 0, 0, 8'h10, 0, 8'h00, 1, 8'hA5, 0);
      // Back-to-back writes 0x01 <- 0x11, 0x02 <- 0x22
      vt[6]  = mkv(1, 1, 8'h01, 8'h11, 0, 8'h00, 1, 1, 0, 8'h01, 1, 8'h11, 0, 8'h00, 0);
      vt[7]  = mkv(1, 1, 8'h02, 8'h22, 0, 8'h00, 0, 1, 1, 8'h01, 1, 8'h11, 0, 8'h00, 0);
      vt[8]  = mkv(1, 1, 8'h02, 8'h22, 1, 8'h00, 1, 1, 0, 8'h02, 1, 8'h22, 1, 8'h00, 0);
      vt[9]  = mkv(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 8'h02, 1, 8'h22, 0, 8'h00, 0);
      vt[10] = mkv(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 8'h02, 1, 8'h22, 1, 8'h00, 0);
      // Three wait states; command lines wiggle while the bus must hold
      vt[11] = mkv(1, 1, 8'h33, 8'h5C, 0, 8'h00, 1, 1, 0, 8'h33, 1, 8'h5C, 0, 8'h00, 0);
      vt[12] = mkv(0, 0, 8'hFF, 8'h00, 0, 8'h00, 0, 1, 1, 8'h33, 1, 8'h5C, 0, 8'h00, 0);
      vt[13] = mkv(1, 0, 8'hFF, 8'h00, 0, 8'hEE, 0, 1, 1, 8'h33, 1, 8'h5C, 0, 8'h00, 0);
      vt[14] = mkv(1, 0, 8'hFF, 8'h00, 0, 8'hEE, 0, 1, 1, 8'h33, 1, 8'h5C, 0, 8'h00, 0);
      vt[15] = mkv(1, 0, 8'hFF, 8'h00, 0, 8'hEE, 0, 1, 1, 8'h33, 1, 8'h5C, 0, 8'h00, 0);
      vt[16] = mkv(0, 0, 8'hFF, 8'h00, 1, 8'hEE, 1, 0, 0, 8'h33, 1, 8'h5C, 1, 8'h00, 0);
      vt[17] = mkv(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 8'h33, 1, 8'h5C, 0, 8'h00, 0);

      // Reset state
      prst = 1'b1;
      drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
      repeat (2) @(posedge pclk);
      #1;
      chk("reset cmd_ready", 32'(bus.cmd_ready), 0);
      chk("reset psel",      32'(bus.psel), 0);
      chk("reset pen",       32'(bus.pen), 0);
      chk("reset paddr",     32'(bus.paddr), 0);
      chk("reset pwrite",    32'(bus.pwrite), 0);
      chk("reset pwdata",    32'(bus.pwdata), 0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
      chk("reset rsp_rdata", 32'(bus.rsp_rdata), 0);
      chk("reset rsp_err",   32'(bus.rsp_err), 0);
      prst = 1'b0;

      // Vector table
      for (int i = 0; i < 18; i++) begin
         drive(vt[i].cv, vt[i].cw, vt[i].ca, vt[i].cwd, vt[i].pr, vt[i].prd);
         #4;
         chk($sformatf("v%0d cmd_ready", i), 32'(bus.cmd_ready), 32'(vt[i].e_rdy));
         @(posedge pclk);
         #1;
         chk($sformatf("v%0d psel", i),      32'(bus.psel),      32'(vt[i].e_psel));
         chk($sformatf("v%0d pen", i),       32'(bus.pen),       32'(vt[i].e_pen));
         chk($sformatf("v%0d paddr", i),     32'(bus.paddr),     32'(vt[i].e_paddr));
         chk($sformatf("v%0d pwrite", i),    32'(bus.pwrite),    32'(vt[i].e_pwrite));
         chk($sformatf("v%0d pwdata", i),    32'(bus.pwdata),    32'(vt[i].e_pwdata));
         chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vt[i].e_rv));
         chk($sformatf("v%0d rsp_rdata", i), 32'(bus.rsp_rdata), 32'(vt[i].e_rd));
         chk($sformatf("v%0d rsp_err", i),   32'(bus.rsp_err),   32'(vt[i].e_err));
      end

      // Timeout: pready stuck low, expect 16 ACCESS cycles then an error response
      drive(1, 1, 8'h44, 8'h99, 0, 8'h77);
      #4;
      chk("to cmd_ready idle", 32'(bus.cmd_ready), 1);
      @(posedge pclk);
      #1;
      drive(0, 0, 8'h00, 8'h00, 0, 8'h77);
      acc = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(posedge pclk);
         #1;
         if (bus.rsp_valid) got = 1'b1;
         else if (bus.psel && bus.pen) acc++;
      end
      chk("to rsp seen",     32'(got), 1);
      chk("to access cycles", 32'(acc), 16);
      chk("to psel",         32'(bus.psel), 0);
      chk("to pen",          32'(bus.pen), 0);
      chk("to rsp_err",      32'(bus.rsp_err), 1);
      chk("to rsp_rdata",    32'(bus.rsp_rdata), 0);

      // Normal read after abort
      drive(1, 0, 8'h55, 8'h00, 1, 8'h3C);
      #4;
      chk("post-to cmd_ready", 32'(bus.cmd_ready), 1);
      @(posedge pclk);
      #1;
      chk("post-to setup psel",  32'(bus.psel), 1);
      chk("post-to setup pen",   32'(bus.pen), 0);
      chk("post-to paddr",       32'(bus.paddr), 32'h55);
      chk("post-to rsp_valid 0", 32'(bus.rsp_valid), 0);
      drive(0, 0, 8'h00, 8'h00, 1, 8'h3C);
      @(posedge pclk);
      #1;
      chk("post-to access pen", 32'(bus.pen), 1);
      @(posedge pclk);
      #1;
      chk("post-to rsp_valid", 32'(bus.rsp_valid), 1);
      chk("post-to rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
      chk("post-to rsp_err",   32'(bus.rsp_err), 0);
      chk("post-to psel",      32'(bus.psel), 0);

      // Reset asserted mid-ACCESS
      drive(1, 1, 8'h66, 8'h12, 0, 8'h00);
      @(posedge pclk);
      #1;
      drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
      @(posedge pclk);
      #1;
      chk("rst-mid access pen", 32'(bus.pen), 1);
      @(posedge pclk);
      #1;
      prst = 1'b1;
      #4;
      chk("rst-mid cmd_ready", 32'(bus.cmd_ready), 0);
      @(posedge pclk);
      #1;
      chk("rst-mid psel",      32'(bus.psel), 0);
      chk("rst-mid pen",       32'(bus.pen), 0);
      chk("rst-mid rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst-mid paddr",     32'(bus.paddr), 0);
      prst = 1'b0;
      #4;
      chk("rst-rel cmd_ready", 32'(bus.cmd_ready), 1);
      @(posedge pclk);
      #1;
      chk("rst-rel rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst-rel psel",      32'(bus.psel), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
